pipe_hazard_ctrl: RTL and testbench

- Centralised hazard, forwarding and stall controller for the 5-stage RISC-V pipeline.
- Replaces the separate load-use detector, forwarding unit and branch-flush logic with a single block.
- Keeps its own shadow copy of destination and valid state for the EX, MEM and WB stages.
- Adds a data-memory ready handshake with a whole-pipeline freeze, a bounded wait timeout, and stall/flush performance counters.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 26 ++
 rtl/pipe_hazard_ctrl_if.sv | 53 +++++
 rtl/pipe_hazard_ctrl_hz_fwd_sel.sv | 25 ++
 rtl/pipe_hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

  // Register-index width carried in the shadow stage records.
  localparam int HZ_RD_W = 5;

  // Shadow copy of one downstream stage (EX, MEM or WB).
  typedef struct packed {
    logic               valid;
    logic [HZ_RD_W-1:0] rd;
    logic               regwrite;
    logic               memread;
    logic               memwrite;
  } hz_stage_t;

  typedef enum logic {
    HZ_RUN  = 1'b0,
    HZ_WAIT = 1'b1
  } hz_state_t;

  // Operand source selects for the EX-stage ALU inputs.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle.
interface pipe_hazard_ctrl_if #(
  parameter int RF_ADDRESS = 5,
  parameter int CNT_W      = 32
);
  logic                  id_valid;
  logic [RF_ADDRESS-1:0] id_rs1;
  logic [RF_ADDRESS-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic [RF_ADDRESS-1:0] id_rd;
  logic                  id_regwrite;
  logic                  id_memread;
  logic                  id_memwrite;
  logic [RF_ADDRESS-1:0] ex_rs1;
  logic [RF_ADDRESS-1:0] ex_rs2;
  logic                  ex_br_taken;
  logic                  dm_ready;

  logic                  pc_en;
  logic                  if_id_en;
  logic                  id_ex_en;
  logic                  ex_mem_en;
  logic                  mem_wb_en;
  logic                  if_id_flush;
  logic                  id_ex_bubble;
  logic [1:0]            fwd_a_sel;
  logic [1:0]            fwd_b_sel;
  logic                  mem_wait;
  logic                  mem_err;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  // Pipeline side: presents decode/execute/memory status, consumes controls.
  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regwrite, id_memread, id_memwrite, ex_rs1, ex_rs2,
           ex_br_taken, dm_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush,
           id_ex_bubble, fwd_a_sel, fwd_b_sel, mem_wait, mem_err,
           stall_cnt, flush_cnt
  );

  // Controller side.
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regwrite, id_memread, id_memwrite, ex_rs1, ex_rs2,
           ex_br_taken, dm_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush,
           id_ex_bubble, fwd_a_sel, fwd_b_sel, mem_wait, mem_err,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_hz_fwd_sel.sv
// Per-operand forwarding select: the younger MEM result wins over WB.
module hz_fwd_sel
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int RF_ADDRESS = 5
) (
  input  logic                  mem_wr,
  input  logic [RF_ADDRESS-1:0] mem_rd,
  input  logic                  wb_wr,
  input  logic [RF_ADDRESS-1:0] wb_rd,
  input  logic [RF_ADDRESS-1:0] rs,
  output logic [1:0]            sel
);

  // Pick the newest in-flight producer of rs; x0 is never forwarded.
  always_comb begin
    sel = FWD_RF;
    if (mem_wr && (mem_rd != '0) && (mem_rd == rs)) begin
      sel = FWD_MEM;
    end else if (wb_wr && (wb_rd != '0) && (wb_rd == rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and stall controller for the 5-stage pipeline.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int RF_ADDRESS   = 5,
  parameter int WAIT_W       = 4,
  parameter int MAX_MEM_WAIT = 15,
  parameter int CNT_W        = 32
) (
  input logic               clk,
  input logic               reset,
  pipe_hazard_ctrl_if.slave hz
);

  hz_stage_t         ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  hz_state_t         state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              mem_err_q, mem_err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              mem_access, at_limit, freeze, load_use;
  logic              br_flush, lu_stall, bubble;
  logic              unused_wb_fields;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Freeze, load-use and branch decisions; a branch beats a load-use stall.
  always_comb begin
    mem_access = mem_q.valid & (mem_q.memread | mem_q.memwrite);
    at_limit   = (cnt_q == WAIT_W'(MAX_MEM_WAIT));
    freeze     = ((state_q == HZ_RUN)  & mem_access & ~hz.dm_ready) |
                 ((state_q == HZ_WAIT) & ~hz.dm_ready & ~at_limit);
    load_use   = hz.id_valid & ex_q.valid & ex_q.memread & (ex_q.rd != '0) &
                 ((hz.id_use_rs1 & (hz.id_rs1 == ex_q.rd)) |
                  (hz.id_use_rs2 & (hz.id_rs2 == ex_q.rd)));
    br_flush   = hz.ex_br_taken & ~freeze;
    lu_stall   = load_use & ~freeze & ~br_flush;
    bubble     = br_flush | lu_stall;
  end

  assign hz.pc_en        = ~freeze & ~lu_stall;
  assign hz.if_id_en     = ~freeze & ~lu_stall;
  assign hz.id_ex_en     = ~freeze;
  assign hz.ex_mem_en    = ~freeze;
  assign hz.mem_wb_en    = ~freeze;
  assign hz.if_id_flush  = br_flush;
  assign hz.id_ex_bubble = bubble;
  assign hz.mem_wait     = freeze;
  assign hz.mem_err      = mem_err_q;
  assign hz.stall_cnt    = stall_cnt_q;
  assign hz.flush_cnt    = flush_cnt_q;

  // WB memory-op flags are carried for completeness but never consulted.
  assign unused_wb_fields = wb_q.memread | wb_q.memwrite;

  hz_fwd_sel #(.RF_ADDRESS(RF_ADDRESS)) u_fwd_a (
    .mem_wr (mem_q.valid & mem_q.regwrite),
    .mem_rd (mem_q.rd),
    .wb_wr  (wb_q.valid & wb_q.regwrite),
    .wb_rd  (wb_q.rd),
    .rs     (hz.ex_rs1),
    .sel    (hz.fwd_a_sel)
  );

  hz_fwd_sel #(.RF_ADDRESS(RF_ADDRESS)) u_fwd_b (
    .mem_wr (mem_q.valid & mem_q.regwrite),
    .mem_rd (mem_q.rd),
    .wb_wr  (wb_q.valid & wb_q.regwrite),
    .wb_rd  (wb_q.rd),
    .rs     (hz.ex_rs2),
    .sel    (hz.fwd_b_sel)
  );

  // Memory-wait FSM: a timeout releases the pipeline as if the access completed.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_err_d = 1'b0;
    case (state_q)
      HZ_RUN: begin
        if (mem_access && !hz.dm_ready) begin
          state_d = HZ_WAIT;
          cnt_d   = WAIT_W'(1);
        end
      end
      HZ_WAIT: begin
        if (hz.dm_ready) begin
          state_d = HZ_RUN;
          cnt_d   = '0;
        end else if (at_limit) begin
          mem_err_d = 1'b1;
          state_d   = HZ_RUN;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + WAIT_W'(1);
        end
      end
      default: begin
        state_d = HZ_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Shadow stages shift on every unfrozen edge; a bubble enters EX as invalid.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!freeze) begin
      wb_d           = mem_q;
      mem_d          = ex_q;
      ex_d.valid     = hz.id_valid & ~bubble;
      ex_d.rd        = hz.id_rd;
      ex_d.regwrite  = hz.id_regwrite;
      ex_d.memread   = hz.id_memread;
      ex_d.memwrite  = hz.id_memwrite;
    end
  end

  // Saturating performance counters.
  always_comb begin
    stall_cnt_d = (freeze | lu_stall) ? sat_inc(stall_cnt_q) : stall_cnt_q;
    flush_cnt_d = br_flush ? sat_inc(flush_cnt_q) : flush_cnt_q;
  end

  // Control state, error pulse and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= HZ_RUN;
      cnt_q       <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Shadow stage registers; only the valid bits need a reset value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q.valid  <= 1'b0;
      mem_q.valid <= 1'b0;
      wb_q.valid  <= 1'b0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a queue of expected control vectors.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  localparam int RF_ADDRESS   = 5;
  localparam int WAIT_W       = 4;
  localparam int MAX_MEM_WAIT = 15;
  localparam int CNT_W        = 32;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.RF_ADDRESS(RF_ADDRESS), .CNT_W(CNT_W)) hz ();

  pipe_hazard_ctrl #(
    .RF_ADDRESS   (RF_ADDRESS),
    .WAIT_W       (WAIT_W),
    .MAX_MEM_WAIT (MAX_MEM_WAIT),
    .CNT_W        (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [11:0] exp_q[$];
  logic [11:0] obs_vec;

  assign obs_vec = {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en, hz.mem_wb_en,
                    hz.if_id_flush, hz.id_ex_bubble, hz.fwd_a_sel, hz.fwd_b_sel,
                    hz.mem_wait};

  function automatic logic [11:0] ev(input logic pc, input logic ifid, input logic rest,
                                     input logic fl, input logic bub,
                                     input logic [1:0] fa, input logic [1:0] fb,
                                     input logic w);
    return {pc, ifid, rest, rest, rest, fl, bub, fa, fb, w};
  endfunction

  localparam logic [11:0] NORM = {5'b11111, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [11:0] FRZ  = {5'b00000, 2'b00, 2'b00, 2'b00, 1'b1};
  localparam logic [11:0] LU   = {5'b00111, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [11:0] BRF  = {5'b11111, 2'b11, 2'b00, 2'b00, 1'b0};

  task automatic check_out(input string tag);
    logic [11:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s scoreboard empty, observed=%b", tag, obs_vec);
    end else begin
      e = exp_q.pop_front();
      assert (obs_vec === e) else begin
        n_fail++;
        $error("FAIL %s observed=%b expected=%b", tag, obs_vec, e);
      end
    end
  endtask

  task automatic check_val(input string tag, input logic [CNT_W-1:0] o,
                           input logic [CNT_W-1:0] e);
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  // Called just after a negedge with inputs driven: settle, compare, move to next negedge.
  task automatic step(input string tag, input logic [11:0] e);
    exp_q.push_back(e);
    #1;
    check_out(tag);
    @(negedge clk);
  endtask

  task automatic idle_in();
    hz.id_valid    = 1'b0;
    hz.id_rs1      = '0;
    hz.id_rs2      = '0;
    hz.id_use_rs1  = 1'b0;
    hz.id_use_rs2  = 1'b0;
    hz.id_rd       = '0;
    hz.id_regwrite = 1'b0;
    hz.id_memread  = 1'b0;
    hz.id_memwrite = 1'b0;
    hz.ex_rs1      = '0;
    hz.ex_rs2      = '0;
    hz.ex_br_taken = 1'b0;
    hz.dm_ready    = 1'b1;
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic mw);
    hz.id_valid    = v;
    hz.id_rs1      = rs1;
    hz.id_rs2      = rs2;
    hz.id_use_rs1  = u1;
    hz.id_use_rs2  = u2;
    hz.id_rd       = rd;
    hz.id_regwrite = rw;
    hz.id_memread  = mr;
    hz.id_memwrite = mw;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_in();
    @(negedge clk);
    check_val("rst_stall_cnt", hz.stall_cnt, 0);
    check_val("rst_flush_cnt", hz.flush_cnt, 0);
    check_val("rst_mem_err", CNT_W'(hz.mem_err), 0);
    step("rst_outputs", NORM);
    reset = 1'b0;

    // Load-use: lw x5 then add x6,x5,x1
    drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    step("lw_issue", NORM);
    drive_id(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    hz.ex_rs1 = 5'd1;
    step("lu_stall", LU);
    hz.ex_rs1 = 5'd0;
    check_val("lu_stall_cnt", hz.stall_cnt, 1);
    step("lu_release", NORM);
    idle_in();
    hz.ex_rs1 = 5'd5;
    hz.ex_rs2 = 5'd1;
    check_val("lu_stall_cnt_hold", hz.stall_cnt, 1);
    step("lu_fwd_wb", ev(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, FWD_WB, FWD_RF, 1'b0));

    // x3 producers in MEM and WB: MEM wins; then WB alone
    idle_in();
    drive_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    step("x3_a", NORM);
    step("x3_b", NORM);
    idle_in();
    step("x3_gap", NORM);
    hz.ex_rs1 = 5'd3;
    hz.ex_rs2 = 5'd3;
    step("fwd_mem_prio", ev(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, FWD_MEM, FWD_MEM, 1'b0));
    hz.ex_rs2 = 5'd0;
    step("fwd_wb_only", ev(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, FWD_WB, FWD_RF, 1'b0));

    // Writers of x0 in MEM and WB are never forwarded
    idle_in();
    drive_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    step("x0_a", NORM);
    step("x0_b", NORM);
    idle_in();
    step("x0_gap", NORM);
    step("fwd_x0", NORM);

    // Store in MEM with dm_ready low for three cycles
    idle_in();
    do_reset();
    drive_id(1'b1, 5'd2, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    step("sw_issue", NORM);
    idle_in();
    step("sw_to_mem", NORM);
    hz.dm_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("st_freeze", FRZ);
    hz.dm_ready = 1'b1;
    check_val("st_stall_cnt", hz.stall_cnt, 3);
    step("st_resume", NORM);
    check_val("st_stall_cnt_hold", hz.stall_cnt, 3);

    // Timeout: dm_ready held low until the wait limit
    drive_id(1'b1, 5'd2, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    step("sw2_issue", NORM);
    idle_in();
    step("sw2_to_mem", NORM);
    hz.dm_ready = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      check_val("to_mem_err", CNT_W'(hz.mem_err), (i == 17) ? CNT_W'(1) : CNT_W'(0));
      step("to_cycle", (i <= 15) ? FRZ : NORM);
    end
    check_val("to_stall_cnt", hz.stall_cnt, 18);
    hz.dm_ready = 1'b1;

    // Branch taken together with a load-use hazard
    idle_in();
    do_reset();
    drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    step("lw7_issue", NORM);
    drive_id(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
    hz.ex_br_taken = 1'b1;
    step("br_over_lu", BRF);
    idle_in();
    check_val("br_flush_cnt", hz.flush_cnt, 1);
    check_val("br_stall_cnt", hz.stall_cnt, 0);
    step("br_after", NORM);

    // Branch held during a memory freeze: one flush once released
    drive_id(1'b1, 5'd2, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    step("sw3_issue", NORM);
    idle_in();
    step("sw3_to_mem", NORM);
    hz.dm_ready    = 1'b0;
    hz.ex_br_taken = 1'b1;
    step("br_frz1", FRZ);
    step("br_frz2", FRZ);
    hz.dm_ready = 1'b1;
    step("br_release", BRF);
    hz.ex_br_taken = 1'b0;
    check_val("brf_flush_cnt", hz.flush_cnt, 2);
    check_val("brf_stall_cnt", hz.stall_cnt, 2);
    step("br_done", NORM);

    // Reset asserted while waiting on memory
    drive_id(1'b1, 5'd2, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    step("sw4_issue", NORM);
    idle_in();
    step("sw4_to_mem", NORM);
    hz.dm_ready = 1'b0;
    step("rw_frz1", FRZ);
    step("rw_frz2", FRZ);
    reset = 1'b1;
    #1;
    check_val("rw_stall_cnt", hz.stall_cnt, 0);
    check_val("rw_flush_cnt", hz.flush_cnt, 0);
    check_val("rw_mem_err", CNT_W'(hz.mem_err), 0);
    step("rw_in_reset", NORM);
    reset = 1'b0;
    step("rw_after", NORM);
    step("rw_after2", NORM);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
